icb_slave_mc: RTL and testbench

Multi-channel, parametrised ICB slave register file for the ICB-to-APB bridge. It exposes NCH independent register banks (CONTROL/STATE/WDATA/RDATA/KEY) behind one ICB target port and feeds one write FIFO and one read FIFO per channel. Compared with the single-channel slave, it adds:
- byte-enable merge,
- response backpressure (`icb_rsp_ready`),
- error responses for unmapped or empty accesses,
- a per-channel receive interrupt.

---
 rtl/icb_slave_mc_if.sv | 26 ++
 rtl/icb_slave_mc.sv | 181 ++++++++++++++++++
 tb/tb_icb_slave_mc.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icb_slave_mc_if.sv
// ICB target-port bundle: command and response channels between a bus master and the register slave.
interface icb_slave_mc_if #(
   parameter int unsigned DW = 64,
   parameter int unsigned AW = 32
);
   logic            icb_cmd_valid;
   logic            icb_cmd_ready;
   logic            icb_cmd_read;
   logic [AW-1:0]   icb_cmd_addr;
   logic [DW-1:0]   icb_cmd_wdata;
   logic [DW/8-1:0] icb_cmd_wmask;
   logic            icb_rsp_valid;
   logic            icb_rsp_ready;
   logic [DW-1:0]   icb_rsp_rdata;
   logic            icb_rsp_err;

   modport master (
      output icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
      input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
   );

   modport slave (
      input  icb_cmd_valid, icb_cmd_read, icb_cmd_addr, icb_cmd_wdata, icb_cmd_wmask, icb_rsp_ready,
      output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
   );
endinterface

// File: rtl/icb_slave_mc.sv
// Multi-channel ICB register slave: per-channel CONTROL/STATE/WDATA/RDATA/KEY banks
// feeding one write FIFO and one read FIFO per channel of the ICB-to-APB bridge.
module icb_slave_mc #(
   parameter int unsigned   DW        = 64,
   parameter int unsigned   AW        = 32,
   parameter int unsigned   NCH       = 2,
   parameter logic [AW-1:0] BASE_ADDR = AW'(32'h2000_0000),
   parameter int unsigned   CH_STRIDE = 32'h40
) (
   input  logic              clk,
   input  logic              rst_n,
   icb_slave_mc_if.slave     icb,
   input  logic [NCH-1:0]    wfifo_full,
   output logic [NCH-1:0]    wfifo_wen,
   output logic [NCH*DW-1:0] wfifo_wdata,
   input  logic [NCH-1:0]    rfifo_empty,
   output logic [NCH-1:0]    rfifo_ren,
   input  logic [NCH*DW-1:0] rfifo_rdata,
   input  logic [NCH*2-1:0]  apb_state,
   output logic [NCH*DW-1:0] control,
   output logic [NCH*DW-1:0] key,
   output logic              irq
);

   localparam int unsigned MW  = DW / 8;
   localparam int unsigned SLG = $clog2(CH_STRIDE);

   localparam logic [SLG-1:0] OFF_CTRL = SLG'(32'h00);
   localparam logic [SLG-1:0] OFF_STAT = SLG'(32'h08);
   localparam logic [SLG-1:0] OFF_WDAT = SLG'(32'h10);
   localparam logic [SLG-1:0] OFF_RDAT = SLG'(32'h18);
   localparam logic [SLG-1:0] OFF_KEY  = SLG'(32'h20);

   typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RSP} state_t;

   state_t state, state_nxt;

   logic [AW-1:0]  rel, ch_full;
   logic [SLG-1:0] off;
   logic           in_win;
   logic [NCH-1:0] ch_oh, rd_oh_q, ctrl_b1;
   logic           cur_full, cur_empty;
   logic [1:0]     cur_apb;
   logic [DW-1:0]  cur_ctrl, cur_wdat, cur_key, tgt, mrg, rd_val, rd_cap;
   logic           sel_ctrl, sel_stat, sel_wdat, sel_rdat, sel_key;
   logic           is_rd, wdata_wr, rd_fifo, cmd_err, accept;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                           input logic [DW-1:0] new_v,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] res;
      for (int b = 0; b < MW; b++)
         res[b*8 +: 8] = m[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      return res;
   endfunction

   // Address decode and per-channel operand selection
   always_comb begin
      rel       = icb.icb_cmd_addr - BASE_ADDR;
      ch_full   = rel >> SLG;
      off       = rel[SLG-1:0];
      in_win    = (icb.icb_cmd_addr >= BASE_ADDR) && (ch_full < AW'(NCH));
      ch_oh     = '0;
      cur_full  = 1'b0;
      cur_empty = 1'b0;
      cur_apb   = 2'b00;
      cur_ctrl  = '0;
      cur_wdat  = '0;
      cur_key   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (in_win && (ch_full == AW'(i))) begin
            ch_oh[i]  = 1'b1;
            cur_full  = wfifo_full[i];
            cur_empty = rfifo_empty[i];
            cur_apb   = apb_state[i*2 +: 2];
            cur_ctrl  = control[i*DW +: DW];
            cur_wdat  = wfifo_wdata[i*DW +: DW];
            cur_key   = key[i*DW +: DW];
         end
      end
      sel_ctrl = in_win && (off == OFF_CTRL);
      sel_stat = in_win && (off == OFF_STAT);
      sel_wdat = in_win && (off == OFF_WDAT);
      sel_rdat = in_win && (off == OFF_RDAT);
      sel_key  = in_win && (off == OFF_KEY);
      is_rd    = icb.icb_cmd_read;
      wdata_wr = sel_wdat && !is_rd;
      rd_fifo  = sel_rdat && is_rd && !cur_empty;
      cmd_err  = !(sel_ctrl || sel_wdat || sel_key || (is_rd && (sel_stat || sel_rdat)))
                 || (sel_rdat && is_rd && cur_empty);
      rd_val   = '0;
      if (is_rd) begin
         if (sel_ctrl)      rd_val = cur_ctrl;
         else if (sel_stat) rd_val = DW'({cur_full, cur_empty, cur_apb});
         else if (sel_wdat) rd_val = cur_wdat;
         else if (sel_key)  rd_val = cur_key;
      end
      tgt = sel_ctrl ? cur_ctrl : (sel_wdat ? cur_wdat : cur_key);
      mrg = merge(tgt, icb.icb_cmd_wdata, icb.icb_cmd_wmask);
   end

   // Read-FIFO data capture and interrupt sources
   always_comb begin
      rd_cap  = '0;
      ctrl_b1 = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rd_oh_q[i]) rd_cap = rfifo_rdata[i*DW +: DW];
         ctrl_b1[i] = control[i*DW + 1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = rd_fifo ? S_RD_WAIT : S_RSP;
         S_RD_WAIT: state_nxt = S_RSP;
         S_RSP:     if (icb.icb_rsp_ready) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Only a WDATA write to a full FIFO is held off
   always_comb begin
      icb.icb_cmd_ready = 1'b0;
      accept            = 1'b0;
      rfifo_ren         = '0;
      icb.icb_cmd_ready = (state == S_IDLE) && !(wdata_wr && cur_full);
      accept            = icb.icb_cmd_valid && icb.icb_cmd_ready;
      if (accept && rd_fifo) rfifo_ren = ch_oh;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         icb.icb_rsp_valid <= 1'b0;
         icb.icb_rsp_rdata <= '0;
         icb.icb_rsp_err   <= 1'b0;
         wfifo_wen         <= '0;
         wfifo_wdata       <= '0;
         control           <= '0;
         key               <= '0;
         irq               <= 1'b0;
         rd_oh_q           <= '0;
      end else begin
         wfifo_wen <= '0;
         // Uses the pre-write control value, so a CONTROL write shows up one cycle later
         irq       <= |(ctrl_b1 & ~rfifo_empty);
         if (accept) begin
            rd_oh_q <= ch_oh;
            if (!rd_fifo) begin
               icb.icb_rsp_valid <= 1'b1;
               icb.icb_rsp_rdata <= cmd_err ? '0 : rd_val;
               icb.icb_rsp_err   <= cmd_err;
            end
            if (!is_rd && !cmd_err) begin
               for (int i = 0; i < NCH; i++) begin
                  if (ch_oh[i]) begin
                     if (sel_ctrl) control[i*DW +: DW] <= mrg;
                     if (sel_key)  key[i*DW +: DW]     <= mrg;
                     if (sel_wdat) begin
                        wfifo_wdata[i*DW +: DW] <= mrg;
                        wfifo_wen[i]            <= 1'b1;
                     end
                  end
               end
            end
         end else if (state == S_RD_WAIT) begin
            icb.icb_rsp_valid <= 1'b1;
            icb.icb_rsp_rdata <= rd_cap;
            icb.icb_rsp_err   <= 1'b0;
         end else if (icb.icb_rsp_valid && icb.icb_rsp_ready) begin
            icb.icb_rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_icb_slave_mc.sv
// Directed bench for icb_slave_mc (DW=64, NCH=2): register access, FIFO handshakes, errors, backpressure, irq.
module tb_icb_slave_mc;

   localparam int unsigned DW  = 64;
   localparam int unsigned AW  = 32;
   localparam int unsigned NCH = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH-1:0]    wfifo_full;
   logic [NCH-1:0]    wfifo_wen;
   logic [NCH*DW-1:0] wfifo_wdata;
   logic [NCH-1:0]    rfifo_empty;
   logic [NCH-1:0]    rfifo_ren;
   logic [NCH*DW-1:0] rfifo_rdata;
   logic [NCH*2-1:0]  apb_state;
   logic [NCH*DW-1:0] control;
   logic [NCH*DW-1:0] key;
   logic              irq;

   int pass_cnt  = 0;
   int total_cnt = 0;

   icb_slave_mc_if #(.DW(DW), .AW(AW)) icb ();

   icb_slave_mc #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .icb         (icb.slave),
      .wfifo_full  (wfifo_full),
      .wfifo_wen   (wfifo_wen),
      .wfifo_wdata (wfifo_wdata),
      .rfifo_empty (rfifo_empty),
      .rfifo_ren   (rfifo_ren),
      .rfifo_rdata (rfifo_rdata),
      .apb_state   (apb_state),
      .control     (control),
      .key         (key),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   // Present a command at a falling edge and return at the falling edge after it is accepted
   task automatic send(input logic rd, input logic [31:0] a, input logic [63:0] wd, input logic [7:0] wm);
      int n;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_read  = rd;
      icb.icb_cmd_addr  = a;
      icb.icb_cmd_wdata = wd;
      icb.icb_cmd_wmask = wm;
      n = 0;
      #1;
      while (!icb.icb_cmd_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 20) begin
         total_cnt++;
         $display("FAIL send_timeout addr=%h cmd_ready stayed %b, need 1", a, icb.icb_cmd_ready);
      end
      @(negedge clk);
      icb.icb_cmd_valid = 1'b0;
   endtask

   // Wait (bounded) for the response, capture it and let it be consumed
   task automatic wait_rsp(output int lat, output logic [63:0] d, output logic e);
      lat = 1;
      while (!icb.icb_rsp_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      d = icb.icb_rsp_rdata;
      e = icb.icb_rsp_err;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      total_cnt++;
      if (icb.icb_rsp_valid !== 1'b0 || icb.icb_rsp_err !== 1'b0 || icb.icb_rsp_rdata !== 64'h0)
         $display("FAIL reset_rsp got v=%b e=%b d=%h, need 0/0/0", icb.icb_rsp_valid, icb.icb_rsp_err, icb.icb_rsp_rdata);
      else pass_cnt++;
      total_cnt++;
      if (wfifo_wen !== 2'b00 || wfifo_wdata !== 128'h0 || rfifo_ren !== 2'b00)
         $display("FAIL reset_fifo got wen=%b wd=%h ren=%b, need zeros", wfifo_wen, wfifo_wdata, rfifo_ren);
      else pass_cnt++;
      total_cnt++;
      if (control !== 128'h0 || key !== 128'h0 || irq !== 1'b0)
         $display("FAIL reset_regs got ctrl=%h key=%h irq=%b, need zeros", control, key, irq);
      else pass_cnt++;
      total_cnt++;
      if (icb.icb_cmd_ready !== 1'b1)
         $display("FAIL reset_ready got %b, need 1", icb.icb_cmd_ready);
      else pass_cnt++;
   endtask

   task automatic test_masked_write();
      int lat;
      logic [63:0] d;
      logic e;
      send(1'b0, 32'h2000_0040, 64'h1122334455667788, 8'h0F);
      total_cnt++;
      if (icb.icb_rsp_valid !== 1'b1 || icb.icb_rsp_err !== 1'b0 || icb.icb_rsp_rdata !== 64'h0)
         $display("FAIL mwr_rsp got v=%b e=%b d=%h, need 1/0/0", icb.icb_rsp_valid, icb.icb_rsp_err, icb.icb_rsp_rdata);
      else pass_cnt++;
      total_cnt++;
      if (control[127:64] !== 64'h0000000055667788 || control[63:0] !== 64'h0 || wfifo_wen !== 2'b00)
         $display("FAIL mwr_ctrl1 got ctrl=%h wen=%b, need ch1=0000000055667788 ch0=0 wen=0", control, wfifo_wen);
      else pass_cnt++;
      wait_rsp(lat, d, e);
      send(1'b0, 32'h2000_0040, 64'hAAAAAAAA_BBBBBBBB, 8'hF0);
      wait_rsp(lat, d, e);
      send(1'b1, 32'h2000_0040, 64'h0, 8'h00);
      wait_rsp(lat, d, e);
      total_cnt++;
      if (lat !== 1 || d !== 64'hAAAAAAAA55667788 || e !== 1'b0)
         $display("FAIL mwr_readback got lat=%0d d=%h e=%b, need 1 AAAAAAAA55667788 0", lat, d, e);
      else pass_cnt++;
      send(1'b0, 32'h2000_0020, 64'h0123456789ABCDEF, 8'hFF);
      wait_rsp(lat, d, e);
      total_cnt++;
      if (key[63:0] !== 64'h0123456789ABCDEF || e !== 1'b0)
         $display("FAIL key_write got key0=%h e=%b, need 0123456789abcdef 0", key[63:0], e);
      else pass_cnt++;
   endtask

   task automatic test_wdata_full();
      int lat;
      logic [63:0] d;
      logic e;
      int busy;
      wfifo_full = 2'b01;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_read  = 1'b0;
      icb.icb_cmd_addr  = 32'h2000_0010;
      icb.icb_cmd_wdata = 64'hCAFEF00D_12345678;
      icb.icb_cmd_wmask = 8'hFF;
      busy = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (icb.icb_cmd_ready !== 1'b0 || wfifo_wen !== 2'b00) busy++;
         @(negedge clk);
      end
      total_cnt++;
      if (busy != 0) $display("FAIL full_hold got %0d cycles ready/wen active, need 0", busy);
      else pass_cnt++;
      wfifo_full = 2'b00;
      #1;
      total_cnt++;
      if (icb.icb_cmd_ready !== 1'b1) $display("FAIL full_release ready got %b, need 1", icb.icb_cmd_ready);
      else pass_cnt++;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b0;
      total_cnt++;
      if (wfifo_wen !== 2'b01 || wfifo_wdata[63:0] !== 64'hCAFEF00D12345678 || icb.icb_rsp_valid !== 1'b1)
         $display("FAIL full_wen got wen=%b wd=%h v=%b, need 01 cafef00d12345678 1", wfifo_wen, wfifo_wdata[63:0], icb.icb_rsp_valid);
      else pass_cnt++;
      wait_rsp(lat, d, e);
      total_cnt++;
      if (wfifo_wen !== 2'b00) $display("FAIL full_wen_pulse got wen=%b, need 00", wfifo_wen);
      else pass_cnt++;
      send(1'b0, 32'h2000_0010, 64'hFFFFFFFF_FFFFFFFF, 8'h03);
      total_cnt++;
      if (wfifo_wen !== 2'b01 || wfifo_wdata[63:0] !== 64'hCAFEF00D1234FFFF)
         $display("FAIL wdata_merge got wen=%b wd=%h, need 01 cafef00d1234ffff", wfifo_wen, wfifo_wdata[63:0]);
      else pass_cnt++;
      wait_rsp(lat, d, e);
      wfifo_full = 2'b01;
      send(1'b0, 32'h2000_0050, 64'h5555, 8'hFF);
      total_cnt++;
      if (wfifo_wen !== 2'b10 || wfifo_wdata[127:64] !== 64'h5555)
         $display("FAIL wdata_ch1 got wen=%b wd1=%h, need 10 0000000000005555", wfifo_wen, wfifo_wdata[127:64]);
      else pass_cnt++;
      wait_rsp(lat, d, e);
      wfifo_full = 2'b00;
   endtask

   task automatic test_rdata_read();
      int lat;
      logic [63:0] d;
      logic e;
      rfifo_empty = 2'b01;
      rfifo_rdata = {64'h1111, 64'h0};
      @(negedge clk);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_read  = 1'b1;
      icb.icb_cmd_addr  = 32'h2000_0058;
      #1;
      total_cnt++;
      if (rfifo_ren !== 2'b10 || icb.icb_cmd_ready !== 1'b1)
         $display("FAIL rd_ren got ren=%b ready=%b, need 10 1", rfifo_ren, icb.icb_cmd_ready);
      else pass_cnt++;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b0;
      rfifo_rdata = {64'hDEADBEEF, 64'h0};
      #1;
      total_cnt++;
      if (rfifo_ren !== 2'b00 || icb.icb_rsp_valid !== 1'b0)
         $display("FAIL rd_wait got ren=%b v=%b, need 00 0", rfifo_ren, icb.icb_rsp_valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (icb.icb_rsp_valid !== 1'b1 || icb.icb_rsp_rdata !== 64'hDEADBEEF || icb.icb_rsp_err !== 1'b0)
         $display("FAIL rd_data got v=%b d=%h e=%b, need 1 deadbeef 0", icb.icb_rsp_valid, icb.icb_rsp_rdata, icb.icb_rsp_err);
      else pass_cnt++;
      @(negedge clk);
      rfifo_empty = 2'b11;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_read  = 1'b1;
      icb.icb_cmd_addr  = 32'h2000_0018;
      #1;
      total_cnt++;
      if (rfifo_ren !== 2'b00 || icb.icb_cmd_ready !== 1'b1)
         $display("FAIL rd_empty_ren got ren=%b ready=%b, need 00 1", rfifo_ren, icb.icb_cmd_ready);
      else pass_cnt++;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b0;
      wait_rsp(lat, d, e);
      total_cnt++;
      if (lat !== 1 || d !== 64'h0 || e !== 1'b1)
         $display("FAIL rd_empty_rsp got lat=%0d d=%h e=%b, need 1 0 1", lat, d, e);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      int lat;
      logic [63:0] d;
      logic e;
      send(1'b0, 32'h2000_0008, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
      wait_rsp(lat, d, e);
      total_cnt++;
      if (e !== 1'b1 || d !== 64'h0 || control[63:0] !== 64'h0)
         $display("FAIL err_wr_state got e=%b d=%h ctrl0=%h, need 1 0 0", e, d, control[63:0]);
      else pass_cnt++;
      send(1'b1, 32'h2000_0080, 64'h0, 8'h00);
      wait_rsp(lat, d, e);
      total_cnt++;
      if (e !== 1'b1 || d !== 64'h0) $display("FAIL err_ch_range got e=%b d=%h, need 1 0", e, d);
      else pass_cnt++;
      send(1'b1, 32'h1FFF_FFF8, 64'h0, 8'h00);
      wait_rsp(lat, d, e);
      total_cnt++;
      if (e !== 1'b1 || d !== 64'h0) $display("FAIL err_below_base got e=%b d=%h, need 1 0", e, d);
      else pass_cnt++;
      send(1'b1, 32'h2000_0028, 64'h0, 8'h00);
      wait_rsp(lat, d, e);
      total_cnt++;
      if (e !== 1'b1 || d !== 64'h0) $display("FAIL err_bad_off got e=%b d=%h, need 1 0", e, d);
      else pass_cnt++;
      wfifo_full  = 2'b10;
      rfifo_empty = 2'b10;
      apb_state   = 4'b10_01;
      send(1'b1, 32'h2000_0048, 64'h0, 8'h00);
      wait_rsp(lat, d, e);
      total_cnt++;
      if (e !== 1'b0 || d !== 64'hE) $display("FAIL state_read got e=%b d=%h, need 0 000000000000000e", e, d);
      else pass_cnt++;
      wfifo_full  = 2'b00;
      rfifo_empty = 2'b11;
      apb_state   = 4'b00_00;
   endtask

   task automatic test_backpressure();
      int bad;
      icb.icb_rsp_ready = 1'b0;
      send(1'b1, 32'h2000_0040, 64'h0, 8'h00);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (icb.icb_rsp_valid !== 1'b1 || icb.icb_rsp_rdata !== 64'hAAAAAAAA55667788 ||
             icb.icb_rsp_err !== 1'b0 || icb.icb_cmd_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      total_cnt++;
      if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles, need 0", bad);
      else pass_cnt++;
      icb.icb_rsp_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (icb.icb_rsp_valid !== 1'b0 || icb.icb_cmd_ready !== 1'b1)
         $display("FAIL bp_release got v=%b ready=%b, need 0 1", icb.icb_rsp_valid, icb.icb_cmd_ready);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int accepts;
      logic [63:0] last_d;
      @(negedge clk);
      icb.icb_cmd_valid = 1'b1;
      icb.icb_cmd_read  = 1'b1;
      icb.icb_cmd_addr  = 32'h2000_0020;
      accepts = 0;
      last_d  = 64'h0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (icb.icb_cmd_ready === 1'b1) accepts++;
         if (k == 5) last_d = icb.icb_rsp_rdata;
         @(negedge clk);
      end
      icb.icb_cmd_valid = 1'b0;
      total_cnt++;
      if (accepts !== 3 || last_d !== 64'h0123456789ABCDEF)
         $display("FAIL b2b got accepts=%0d d=%h, need 3 0123456789abcdef", accepts, last_d);
      else pass_cnt++;
   endtask

   task automatic test_irq();
      int lat;
      logic [63:0] d;
      logic e;
      send(1'b0, 32'h2000_0000, 64'h2, 8'h01);
      wait_rsp(lat, d, e);
      total_cnt++;
      if (irq !== 1'b0 || control[63:0] !== 64'h2)
         $display("FAIL irq_idle got irq=%b ctrl0=%h, need 0 2", irq, control[63:0]);
      else pass_cnt++;
      rfifo_empty = 2'b10;
      @(negedge clk);
      total_cnt++;
      if (irq !== 1'b1) $display("FAIL irq_rise got %b, need 1", irq);
      else pass_cnt++;
      send(1'b0, 32'h2000_0000, 64'h0, 8'h01);
      total_cnt++;
      if (irq !== 1'b1 || control[63:0] !== 64'h0)
         $display("FAIL irq_old_ctrl got irq=%b ctrl0=%h, need 1 0", irq, control[63:0]);
      else pass_cnt++;
      wait_rsp(lat, d, e);
      total_cnt++;
      if (irq !== 1'b0) $display("FAIL irq_fall got %b, need 0", irq);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      rfifo_empty = 2'b00;
      send(1'b1, 32'h2000_0018, 64'h0, 8'h00);
      rst_n = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (icb.icb_rsp_valid !== 1'b0 || control !== 128'h0 || key !== 128'h0 || wfifo_wdata !== 128'h0)
         $display("FAIL reset_mid got v=%b ctrl=%h key=%h wd=%h, need zeros", icb.icb_rsp_valid, control, key, wfifo_wdata);
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      total_cnt++;
      if (icb.icb_cmd_ready !== 1'b1 || icb.icb_rsp_valid !== 1'b0)
         $display("FAIL reset_mid_idle got ready=%b v=%b, need 1 0", icb.icb_cmd_ready, icb.icb_rsp_valid);
      else pass_cnt++;
   endtask

   initial begin
      rst_n             = 1'b0;
      wfifo_full        = '0;
      rfifo_empty       = 2'b11;
      rfifo_rdata       = '0;
      apb_state         = '0;
      icb.icb_cmd_valid = 1'b0;
      icb.icb_cmd_read  = 1'b0;
      icb.icb_cmd_addr  = '0;
      icb.icb_cmd_wdata = '0;
      icb.icb_cmd_wmask = '0;
      icb.icb_rsp_ready = 1'b1;
      test_reset();
      test_masked_write();
      test_wdata_full();
      test_rdata_read();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_irq();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
